csa_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-select adder/subtractor with valid/ready flow control. It generalises the fixed 8-bit, 4-bit-block carry-select adder to any width and block size. Each block's conditional sums are precomputed in stage 1, and the carry-select chain is resolved in stage 2. It sits between operand producers and consumers in the datapath and sustains one operation per cycle under backpressure.

---
 rtl/csa_pipe.sv | 122 ++++++++++++
 tb/tb_csa_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
// Define CSA_PIPE_OVF_EN to enable the registered signed-overflow output; otherwise ovf is tied to 0.
module csa_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;
    // Blocks 1..NBLK-1 need a carry-in-1 variant; keep the array non-empty when NBLK == 1.
    localparam int NH   = (NBLK > 1) ? NBLK - 1 : 1;

    logic             advance;
    logic [WIDTH-1:0] bk;

    // Stage-1 combinational block sums (BLK+1 bits: sum plus block carry).
    logic [BLK:0]     s0_w [NBLK];
    logic [BLK:0]     s1_w [NH];

    logic             s1_v_reg;
    logic [BLK:0]     s0_reg [NBLK];
    logic [BLK:0]     s1_reg [NH];

    logic [WIDTH-1:0] sum_next;
    logic             carry_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;

    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;
    assign bk       = sub ? ~b : b;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            if (gi == 0) begin : g_first
                // Block 0 knows its carry-in (sub) already, so only the selected sum is kept.
                assign s0_w[gi] = {1'b0, a[BLK-1:0]} + {1'b0, bk[BLK-1:0]} + {{BLK{1'b0}}, sub};
                if (NBLK == 1) begin : g_tie
                    assign s1_w[0] = '0;
                end
            end else begin : g_sel
                assign s0_w[gi]   = {1'b0, a[gi*BLK +: BLK]} + {1'b0, bk[gi*BLK +: BLK]};
                assign s1_w[gi-1] = {1'b0, a[gi*BLK +: BLK]} + {1'b0, bk[gi*BLK +: BLK]}
                                    + (BLK+1)'(1);
            end
        end
    endgenerate

    // Stage-2 carry-select chain: each block's carry-in picks the neighbour's precomputed result.
    always_comb begin
        logic c;
        sum_next           = '0;
        sum_next[BLK-1:0]  = s0_reg[0][BLK-1:0];
        c                  = s0_reg[0][BLK];
        for (int k = 1; k < NBLK; k++) begin
            sum_next[k*BLK +: BLK] = c ? s1_reg[k-1][BLK-1:0] : s0_reg[k][BLK-1:0];
            c                      = c ? s1_reg[k-1][BLK]     : s0_reg[k][BLK];
        end
        carry_next = c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg      <= 1'b0;
            for (int k = 0; k < NBLK; k++) s0_reg[k] <= '0;
            for (int k = 0; k < NH; k++)   s1_reg[k] <= '0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
        end else if (advance) begin
            s1_v_reg      <= in_valid;
            s0_reg        <= s0_w;
            s1_reg        <= s1_w;
            out_valid_reg <= s1_v_reg;
            sum_reg       <= sum_next;
            carry_reg     <= carry_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign carry     = carry_reg;

`ifdef CSA_PIPE_OVF_EN
    logic a_msb_reg;
    logic bk_msb_reg;
    logic ovf_reg;

    // Overflow uses the effective operand bk, so one rule covers add and subtract.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_reg  <= 1'b0;
            bk_msb_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (advance) begin
            a_msb_reg  <= a[WIDTH-1];
            bk_msb_reg <= bk[WIDTH-1];
            ovf_reg    <= (a_msb_reg == bk_msb_reg) && (sum_next[WIDTH-1] != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// Self-checking bench for csa_pipe: 16/4 and 32/8 instances driven in lockstep,
// directed corner cases plus random streams checked against an arithmetic reference model.
module tb_csa_pipe;

`ifdef CSA_PIPE_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, sub;
    logic [15:0] a16, b16, sum16;
    logic [31:0] a32, b32, sum32;
    logic        ir16, ir32, ov16, ov32, c16, c32, o16, o32;

    always #5 clk = ~clk;

    csa_pipe #(.WIDTH(16), .BLK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a16), .b(b16), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
        .sum(sum16), .carry(c16), .ovf(o16)
    );

    csa_pipe #(.WIDTH(32), .BLK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .a(a32), .b(b32), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
        .sum(sum32), .carry(c32), .ovf(o32)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    res_t        q16[$];
    res_t        q32[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          pops = 0;
    int          pops_before;
    bit          prev_stall = 0;
    bit          last_xfer = 0;
    logic [15:0] prev_s16;
    logic [31:0] prev_s32;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic res_t model(logic [31:0] x, logic [31:0] y, logic s, int w);
        longint m, ux, uy, sx, sy, r;
        res_t   e;
        m    = longint'(1) << w;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[w-1] ? ux - m : ux;
        sy   = y[w-1] ? uy - m : uy;
        r    = s ? sx - sy : sx + sy;
        e.s  = 32'((s ? ux - uy + m : ux + uy) % m);
        e.c  = s ? (ux >= uy) : (ux + uy >= m);
        e.o  = OVF_ON && (r >= m / 2 || r < -(m / 2));
        return e;
    endfunction

    task automatic rand_ops();
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        sub = 1'($urandom);
    endtask

    // One clock cycle: check the current cycle at negedge, then advance past the rising edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        chk("in_ready16", ir16, !ov16 || out_ready);
        chk("in_ready32", ir32, !ov32 || out_ready);
        if (rst) begin
            q16.delete();
            q32.delete();
            prev_stall = 0;
            last_xfer  = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", ov16, 1'b1);
                chk("hold_sum16", sum16, prev_s16);
                chk("hold_sum32", sum32, prev_s32);
            end
            if (ov16 && out_ready) begin
                if (q16.size() == 0) begin
                    chk("unexpected16", ov16, 1'b0);
                end else begin
                    e = q16.pop_front();
                    chk("sum16", sum16, e.s[15:0]);
                    chk("carry16", c16, e.c);
                    chk("ovf16", o16, e.o);
                    pops++;
                end
            end
            if (ov32 && out_ready) begin
                if (q32.size() == 0) begin
                    chk("unexpected32", ov32, 1'b0);
                end else begin
                    e = q32.pop_front();
                    chk("sum32", sum32, e.s);
                    chk("carry32", c32, e.c);
                    chk("ovf32", o32, e.o);
                end
            end
            if (in_valid && ir16) begin
                q16.push_back(model({16'h0, a16}, {16'h0, b16}, sub, 16));
                q32.push_back(model(a32, b32, sub, 32));
            end
            last_xfer  = in_valid && ir16;
            prev_stall = ov16 && !out_ready;
            prev_s16   = sum16;
            prev_s32   = sum32;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(string tag, logic [15:0] x, logic [15:0] y, logic s,
                            logic [15:0] es, logic ec, logic eo);
        a16 = x;
        b16 = y;
        sub = s;
        a32 = $urandom;
        b32 = $urandom;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid_c1"}, ov16, 1'b0);
        step();
        chk({tag, "_valid_c2"}, ov16, 1'b1);
        chk({tag, "_sum"}, sum16, es);
        chk({tag, "_carry"}, c16, ec);
        chk({tag, "_ovf"}, o16, eo & OVF_ON);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0; sub = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_out_valid", ov16, 1'b0);
        chk("rst_sum", sum16, 16'h0000);
        chk("rst_carry", c16, 1'b0);
        chk("rst_ovf", o16, 1'b0);
        chk("rst_in_ready", ir16, 1'b1);

        directed("ripple", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("subneg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        step();

        // Ten back-to-back operations: results must arrive in ten consecutive cycles.
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("stream_pops_mid", pops, 8);
        step();
        step();
        chk("stream_pops_end", pops, 10);
        chk("stream_empty", q16.size(), 0);

        // Random backpressure; operands change only after a transfer or while idle.
        pops = 0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom % 3) != 0;
            if (!in_valid || last_xfer) begin
                in_valid = ($urandom % 4) != 0;
                rand_ops();
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q16.size() != 0 || q32.size() != 0); i++) step();
        chk("bp_drain16", q16.size(), 0);
        chk("bp_drain32", q32.size(), 0);
        chk("bp_some_results", pops > 100, 1'b1);

        // Reset with both stages full and the output stalled.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_ops();
        step();
        rand_ops();
        step();
        rand_ops();
        step();
        chk("full_stall_in_ready", ir16, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", ov16, 1'b0);
        chk("midrst_sum16", sum16, 16'h0000);
        chk("midrst_in_ready", ir16, 1'b1);
        chk("midrst_out_valid32", ov32, 1'b0);
        chk("midrst_sum32", sum32, 32'h0);
        chk("midrst_ovf", o16, 1'b0);
        out_ready = 1'b1;
        pops_before = pops;
        repeat (6) step();
        chk("midrst_no_stale", pops, pops_before);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
